// File: rtl/md_controller_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, latency defaults,
// the HI/LO result pair and small op-classification helpers.
package md_controller_pkg;

   localparam int ALU_OP_LEN = 5;

   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULT  = 5'h10;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MULTU = 5'h11;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIV   = 5'h12;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_DIVU  = 5'h13;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFHI  = 5'h14;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MFLO  = 5'h15;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTHI  = 5'h16;
   localparam logic [ALU_OP_LEN-1:0] ALU_OP_MTLO  = 5'h17;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_result_t;

   function automatic logic is_md_start(input logic [ALU_OP_LEN-1:0] op);
      case (op)
         ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU: return 1'b1;
         default:                                            return 1'b0;
      endcase
   endfunction

   function automatic logic is_div(input logic [ALU_OP_LEN-1:0] op);
      case (op)
         ALU_OP_DIV, ALU_OP_DIVU: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath: produces the {hi,lo} pair for the op in
// execute and flags a divide by zero so the controller can suppress the write.
module md_compute
   import md_controller_pkg::*;
(
   input  logic [ALU_OP_LEN-1:0] op,
   input  logic [31:0]           src0,
   input  logic [31:0]           src1,
   output md_result_t            result,
   output logic                  div0
);

   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic signed [31:0] squot;
   logic signed [31:0] srem;
   logic        [31:0] uquot;
   logic        [31:0] urem;
   logic               zero_divisor;
   logic               signed_ovf;

   assign sprod        = $signed({{32{src0[31]}}, src0}) * $signed({{32{src1[31]}}, src1});
   assign uprod        = {32'd0, src0} * {32'd0, src1};
   assign zero_divisor = (src1 == 32'd0);
   // -2^31 / -1 overflows; pin it to the wrapped quotient and a zero remainder
   assign signed_ovf   = (src0 == 32'h8000_0000) && (src1 == 32'hFFFF_FFFF);
   assign div0         = is_div(op) && zero_divisor;

   // Quotient/remainder, guarded against the zero-divisor and overflow corners
   always_comb begin
      squot = 32'sd0;
      srem  = 32'sd0;
      uquot = 32'd0;
      urem  = 32'd0;
      if (zero_divisor) begin
         squot = 32'sd0;
         srem  = 32'sd0;
      end else begin
         uquot = src0 / src1;
         urem  = src0 % src1;
         if (signed_ovf) begin
            squot = 32'sh8000_0000;
            srem  = 32'sd0;
         end else begin
            squot = $signed(src0) / $signed(src1);
            srem  = $signed(src0) % $signed(src1);
         end
      end
   end

   // Select the result pair for the op
   always_comb begin
      result = '{hi: 32'd0, lo: 32'd0};
      case (op)
         ALU_OP_MULT:  result = sprod;
         ALU_OP_MULTU: result = uprod;
         ALU_OP_DIV:   result = '{hi: srem, lo: squot};
         ALU_OP_DIVU:  result = '{hi: urem, lo: uquot};
         default:      result = '{hi: 32'd0, lo: 32'd0};
      endcase
   end

endmodule

// File: rtl/md_controller.sv
// Multiply/divide sequencer for the execute stage: latches the result at start, counts
// down the unit latency, owns HI/LO and asks the hazard logic to stall decode.
module md_controller
   import md_controller_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  op_valid,
   input  logic [ALU_OP_LEN-1:0] alu_op,
   input  logic [31:0]           src0,
   input  logic [31:0]           src1,
   input  logic                  decode_md,
   output logic                  busy,
   output logic                  stall,
   output logic [31:0]           read_data,
   output logic [31:0]           hi,
   output logic [31:0]           lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] count;
   md_result_t    pending;
   logic          pending_wr;
   md_result_t    comp;
   logic          div0;
   logic          start;

   md_compute u_compute (
      .op     (alu_op),
      .src0   (src0),
      .src1   (src1),
      .result (comp),
      .div0   (div0)
   );

   assign busy  = (count != {CW{1'b0}});
   assign start = op_valid && !busy && is_md_start(alu_op);
   assign stall = decode_md && (busy || start);

   // mfhi/mflo read port; reads architectural HI/LO, never the pending result
   always_comb begin
      read_data = 32'd0;
      case (alu_op)
         ALU_OP_MFHI: read_data = hi;
         ALU_OP_MFLO: read_data = lo;
         default:     read_data = 32'd0;
      endcase
   end

   // Countdown, pending result capture and HI/LO updates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= {CW{1'b0}};
         pending    <= '{hi: 32'd0, lo: 32'd0};
         pending_wr <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
      end else if (busy) begin
         count <= count - CW'(1);
         if ((count == CW'(1)) && pending_wr) begin
            hi <= pending.hi;
            lo <= pending.lo;
         end else begin
            hi <= hi;
            lo <= lo;
         end
      end else if (start) begin
         pending    <= comp;
         pending_wr <= !div0;
         count      <= is_div(alu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (op_valid && (alu_op == ALU_OP_MTHI)) begin
         hi <= src0;
      end else if (op_valid && (alu_op == ALU_OP_MTLO)) begin
         lo <= src0;
      end else begin
         count <= count;
      end
   end

endmodule

// File: tb/tb_md_controller.sv
// Bench for md_controller: directed scenarios with hand-computed results, then random
// traffic checked every cycle against a deadline-based behavioural model.
module tb_md_controller;
   import md_controller_pkg::*;

   localparam int MC = MD_MULT_CYCLES;
   localparam int DC = MD_DIV_CYCLES;
   localparam logic [4:0] OP_NOP = 5'h00;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [4:0]  alu_op = 5'h00;
   logic [31:0] src0 = 32'd0;
   logic [31:0] src1 = 32'd0;
   logic        decode_md = 1'b0;
   logic        busy, stall;
   logic [31:0] read_data, hi, lo;

   md_controller dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .alu_op(alu_op),
      .src0(src0), .src1(src1), .decode_md(decode_md), .busy(busy),
      .stall(stall), .read_data(read_data), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the unit is busy while the cycle index is below a deadline
   longint      cyc, until_cyc;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   bit          m_wr;

   function automatic bit starts(input logic [4:0] op);
      return op == ALU_OP_MULT || op == ALU_OP_MULTU || op == ALU_OP_DIV || op == ALU_OP_DIVU;
   endfunction

   function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r, qa;
      longint unsigned ua, ub;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      t = 64'd0;
      if (op == ALU_OP_MULT) t = sa * sb;
      else if (op == ALU_OP_MULTU) t = ua * ub;
      else if (op == ALU_OP_DIV && b != 32'd0) begin
         qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
         q = ((sa < 0) != (sb < 0)) ? -qa : qa;
         r = sa - q * sb;
         t = {r[31:0], q[31:0]};
      end else if (op == ALU_OP_DIVU && b != 32'd0) begin
         t = {32'(ua % ub), 32'(ua / ub)};
      end
      return t;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc <= 0; until_cyc <= 0; m_hi <= 32'd0; m_lo <= 32'd0; m_pend <= 64'd0; m_wr <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (cyc < until_cyc) begin
            if (cyc + 1 == until_cyc && m_wr) begin
               m_hi <= m_pend[63:32];
               m_lo <= m_pend[31:0];
            end
         end else if (op_valid) begin
            if (starts(alu_op)) begin
               m_pend <= ref_result(alu_op, src0, src1);
               m_wr <= !((alu_op == ALU_OP_DIV || alu_op == ALU_OP_DIVU) && src1 == 32'd0);
               until_cyc <= cyc + 1 + ((alu_op == ALU_OP_DIV || alu_op == ALU_OP_DIVU) ? DC : MC);
            end else if (alu_op == ALU_OP_MTHI) m_hi <= src0;
            else if (alu_op == ALU_OP_MTLO) m_lo <= src0;
         end
      end
   end

   logic        e_busy, e_stall;
   logic [31:0] e_rd;

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         e_busy = (cyc < until_cyc);
         e_stall = decode_md && (e_busy || (op_valid && starts(alu_op)));
         e_rd = (alu_op == ALU_OP_MFHI) ? m_hi : (alu_op == ALU_OP_MFLO) ? m_lo : 32'd0;
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("stall", {31'd0, stall}, {31'd0, e_stall});
         chk("read_data", read_data, e_rd);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   task automatic drive(input bit v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit dmd);
      @(posedge clk);
      #1;
      op_valid = v; alu_op = op; src0 = a; src1 = b; decode_md = dmd;
   endtask

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit dmd,
                         output int nb, output int ns);
      drive(1'b1, op, a, b, dmd);
      @(negedge clk);
      ns = stall ? 1 : 0;
      nb = 0;
      drive(1'b0, OP_NOP, 32'd0, 32'd0, dmd);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         nb++;
         if (stall) ns++;
      end
   endtask

   int nb, ns;
   int r;
   logic [4:0] rop;

   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      check_en = 1'b1;

      run_op(ALU_OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, nb, ns);
      chk("mult_busy_cycles", nb, 32'd5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);

      run_op(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, nb, ns);
      chk("multu_busy_cycles", nb, 32'd5);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      run_op(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
      chk("div_busy_cycles", nb, 32'd10);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      run_op(ALU_OP_DIVU, 32'd7, 32'd0, 1'b0, nb, ns);
      chk("div0_busy_cycles", nb, 32'd10);
      chk("div0_hi", hi, 32'hFFFF_FFFF);
      chk("div0_lo", lo, 32'hFFFF_FFFD);

      run_op(ALU_OP_MULT, 32'd3, 32'd5, 1'b1, nb, ns);
      chk("stall_cycles", ns, 32'd6);
      chk("stall_after_busy", {31'd0, stall}, 32'd0);
      chk("mult35_lo", lo, 32'd15);

      drive(1'b1, ALU_OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
      drive(1'b1, ALU_OP_MFLO, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk("mflo_read", read_data, 32'd15);
      drive(1'b1, ALU_OP_MFHI, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk("mfhi_read", read_data, 32'h0000_1234);

      drive(1'b1, ALU_OP_MULT, 32'd7, 32'd6, 1'b0);
      drive(1'b1, ALU_OP_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
      drive(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
      repeat (8) @(negedge clk);
      chk("mthi_busy_ignored_hi", hi, 32'd0);
      chk("mthi_busy_ignored_lo", lo, 32'd42);

      drive(1'b1, ALU_OP_DIV, 32'd100, 32'd7, 1'b0);
      drive(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_no_write_hi", hi, 32'd0);
      chk("abort_no_write_lo", lo, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) rop = ALU_OP_MULT + 5'($urandom_range(0, 7));
         else rop = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 3) != 0), rop,
               ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom(),
               ($urandom_range(0, 7) == 0) ? 32'd0 :
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) :
               ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom(),
               $urandom_range(0, 1) == 1);
         reset = ($urandom_range(0, 499) == 0);
      end
      drive(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
